noc_packetizer: RTL and testbench
=================================

Name: noc_packetizer

Overview:
Local-port injection stage that builds NoC packets for the router's LOCAL input. It accepts a packet request (destination, source, length) plus a stream of payload words, and emits a flit stream in the `flit_novc_t` layout with HEAD/BODY/TAIL/HEADTAIL labels. The head flit carries the source node ID in the top `MESH_NODE_ID_WIDTH` bits of `head_pl`, so receivers recover it with the standard source-decode utility.

Parameters:
- MESH_SIZE_X, `noc_pkg::MESH_SIZE_X`, mesh columns; `XW = $clog2(MESH_SIZE_X)`.
- MESH_SIZE_Y, `noc_pkg::MESH_SIZE_Y`, mesh rows; `YW = $clog2(MESH_SIZE_Y)`.
- PAYLOAD_DATA_WIDTH, 64, payload word width (PW).
- MAX_PKT_BEATS, 16, maximum payload words per packet; `LW = $clog2(MAX_PKT_BEATS+1)`.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when `req_valid && req_ready`.
- req_x_dest  in  XW  destination column.
- req_y_dest  in  YW  destination row.
- req_src  in  XW+YW  source ID, packed {col, row}.
- req_len  in  LW  payload words in the packet (1..MAX_PKT_BEATS).
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  payload word accepted on handshake.
- pl_data  in  PW  payload word.
- flit_valid  out  1  output flit valid.
- flit_ready  in  1  router LOCAL port can take the flit.
- flit_out  out  2+FLIT_DATA_SIZE  `flit_novc_t`, packed.
- busy  out  1  a packet is in progress (state != IDLE or flit_valid).
- err_len  out  1  one-cycle pulse: request rejected for bad length.
- pkt_count  out  16  packets fully emitted; wraps at 0xFFFF→0.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; flit_valid, pl_ready, err_len, busy = 0; pkt_count=0; flit_out=0.
  - req_ready=0 during reset, 1 in IDLE afterwards.
- FSM states: IDLE, HEAD, STREAM.
- IDLE:
  - req_ready=1 only when the output register is free (`!flit_valid`, or `flit_ready` this cycle).
  - On handshake with `1 <= req_len <= MAX_PKT_BEATS`: latch dest, src and len into `rem=req_len`, then go to HEAD.
  - On handshake with `req_len==0` or `req_len>MAX_PKT_BEATS`: request is consumed, `err_len=1` next cycle, stay IDLE, no flits emitted.
- Output register rule: `pl_ready = (state!=IDLE) && (!flit_valid || flit_ready)`.
  - flit_valid/flit_out hold stable while `flit_valid && !flit_ready`.
- HEAD: on a pl handshake, load the output register next cycle with:
  - label = HEADTAIL if rem==1, else HEAD.
  - x_dest, y_dest from the latched request.
  - `head_pl = {src, pl_data}`.
  - Then `rem--`; go to IDLE if rem was 1, else STREAM.
- STREAM: on each pl handshake, load label = TAIL if rem==1, else BODY.
  - `bt_pl = {(2*(XW+YW)) zeros, pl_data}`, with payload in the LSBs.
  - `rem--`; go to IDLE after TAIL.
- Latency and throughput:
  - Flit appears the cycle after its payload handshake.
  - Sustained rate is 1 flit/cycle with `pl_valid` and `flit_ready` both held high.
  - Request-to-first-payload adds 1 cycle (IDLE→HEAD).
- Back-to-back packets: a new request may be accepted in the same cycle the TAIL/HEADTAIL drains (flit_ready=1). No bubble is required beyond the IDLE cycle.
- pkt_count increments on the cycle the TAIL or HEADTAIL flit handshakes (`flit_valid && flit_ready`), not when it is loaded.
- Simultaneous events:
  - A drain and a load in the same cycle is legal; the register takes the new flit.
  - `pl_valid` in IDLE is ignored (pl_ready=0).
- busy = (state!=IDLE) || flit_valid.
- Reset mid-packet:
  - Discard the partial packet and clear flit_valid immediately.
  - rst is system-wide, so the router is reset in the same cycle; no TAIL is synthesised.
- Width rules:
  - rem is LW bits and never underflows.
  - src is not truncated; `head_pl` MSBs are exactly src.

Test Plan:
- 5x5 mesh (XW=YW=3), req_x_dest=2, y=4, src={3'd1,3'd0}, len=1, payload=64'hDEAD_BEEF_0000_0001 → one flit with label HEADTAIL, x_dest=2, y_dest=4, head_pl[69:64]=6'b001000, head_pl[63:0]=payload; pkt_count=1.
- len=4, payloads 1..4, flit_ready=1 → labels HEAD, BODY, BODY, TAIL on 4 consecutive cycles; bt_pl[63:0]=2,3,4, upper bits 0.
- len=3, flit_ready low for 3 cycles after the HEAD flit → HEAD held stable; pl_ready=0 while the register is full; BODY and TAIL follow once ready rises; no data lost or duplicated.
- req_len=0, then req_len=17 → each request consumed, err_len pulses once each, no flit_valid, pkt_count unchanged.
- Two back-to-back requests (len=2 then len=1) with continuous valid/ready → HEAD, TAIL, HEADTAIL with one IDLE gap; pkt_count=2.
- rst asserted after the BODY flit of a len=5 packet → next cycle flit_valid=0, busy=0, req_ready=1; the next packet (len=1) emits a clean HEADTAIL.

Source files
------------

// File: rtl/noc_packetizer_if.sv
// Handshake bundle between a packet source and the NoC packetizer:
// packet request, payload word stream and the outgoing flit stream.
interface noc_packetizer_if #(
  parameter int XW = 3,
  parameter int YW = 3,
  parameter int PW = 64,
  parameter int LW = 5
);
  localparam int FLIT_DATA_SIZE = 2 * (XW + YW) + PW;

  logic                      req_valid;
  logic                      req_ready;
  logic [XW-1:0]             req_x_dest;
  logic [YW-1:0]             req_y_dest;
  logic [XW+YW-1:0]          req_src;
  logic [LW-1:0]             req_len;

  logic                      pl_valid;
  logic                      pl_ready;
  logic [PW-1:0]             pl_data;

  logic                      flit_valid;
  logic                      flit_ready;
  logic [FLIT_DATA_SIZE+1:0] flit_out;

  // Packet source / router side
  modport master (
    output req_valid, req_x_dest, req_y_dest, req_src, req_len,
    input  req_ready,
    output pl_valid, pl_data,
    input  pl_ready,
    input  flit_valid, flit_out,
    output flit_ready
  );

  // Packetizer side
  modport slave (
    input  req_valid, req_x_dest, req_y_dest, req_src, req_len,
    output req_ready,
    input  pl_valid, pl_data,
    output pl_ready,
    output flit_valid, flit_out,
    input  flit_ready
  );
endinterface

// File: rtl/noc_packetizer.sv
// LOCAL-port injection stage: turns a packet request plus a stream of payload
// words into HEAD/BODY/TAIL (or HEADTAIL) flits. The head flit carries the
// source ID in the MSBs of head_pl. Flit layout, MSB first:
//   {label[1:0], x_dest, y_dest, head_pl}  or  {label[1:0], bt_pl}
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; output register may still be draining
// HEAD   | request latched; next payload word becomes the head flit
// STREAM | emitting BODY flits, last one labelled TAIL
module noc_packetizer #(
  parameter int MESH_SIZE_X        = 5,
  parameter int MESH_SIZE_Y        = 5,
  parameter int PAYLOAD_DATA_WIDTH = 64,
  parameter int MAX_PKT_BEATS      = 16
) (
  input  logic               clk,
  input  logic               rst,
  noc_packetizer_if.slave    bus,
  output logic               busy,
  output logic               err_len,
  output logic [15:0]        pkt_count
);

  localparam int XW  = $clog2(MESH_SIZE_X);
  localparam int YW  = $clog2(MESH_SIZE_Y);
  localparam int PW  = PAYLOAD_DATA_WIDTH;
  localparam int LW  = $clog2(MAX_PKT_BEATS + 1);
  localparam int SW  = XW + YW;
  localparam int FDS = 2 * SW + PW;
  localparam int FW  = FDS + 2;

  typedef enum logic [1:0] {
    LBL_HEAD     = 2'd0,
    LBL_BODY     = 2'd1,
    LBL_TAIL     = 2'd2,
    LBL_HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEAD   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [SW-1:0]   src_q, src_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            flit_valid_q, flit_valid_d;
  logic [FW-1:0]   flit_q, flit_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            out_free;
  logic            req_rdy;
  logic            pl_rdy;
  logic            len_ok;
  logic            last_beat;
  logic            drained_last;
  logic [1:0]      out_lbl;
  flit_label_t     lbl;

  assign out_lbl = flit_q[FW-1 -: 2];

  // Next-state, handshake and output-register load logic
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    src_d        = src_q;
    rem_d        = rem_q;
    flit_valid_d = flit_valid_q;
    flit_d       = flit_q;
    err_d        = 1'b0;
    lbl          = LBL_BODY;

    // The output register can accept a new flit if empty or draining now.
    out_free  = !flit_valid_q || bus.flit_ready;
    req_rdy   = (state_q == S_IDLE) && out_free && !rst;
    pl_rdy    = (state_q != S_IDLE) && out_free;
    len_ok    = (bus.req_len != '0) && (bus.req_len <= LW'(MAX_PKT_BEATS));
    last_beat = (rem_q == LW'(1));

    // Packets are counted when their final flit leaves, not when loaded.
    drained_last = flit_valid_q && bus.flit_ready &&
                   ((out_lbl == LBL_TAIL) || (out_lbl == LBL_HEADTAIL));
    cnt_d = cnt_q + {15'd0, drained_last};

    if (flit_valid_q && bus.flit_ready) begin
      flit_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_rdy) begin
          if (len_ok) begin
            x_d     = bus.req_x_dest;
            y_d     = bus.req_y_dest;
            src_d   = bus.req_src;
            rem_d   = bus.req_len;
            state_d = S_HEAD;
          end else begin
            // Bad length: request is consumed and dropped.
            err_d = 1'b1;
          end
        end
      end
      S_HEAD: begin
        if (bus.pl_valid && pl_rdy) begin
          lbl          = last_beat ? LBL_HEADTAIL : LBL_HEAD;
          flit_valid_d = 1'b1;
          flit_d       = {lbl, x_q, y_q, src_q, bus.pl_data};
          rem_d        = rem_q - LW'(1);
          state_d      = last_beat ? S_IDLE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.pl_valid && pl_rdy) begin
          lbl          = last_beat ? LBL_TAIL : LBL_BODY;
          flit_valid_d = 1'b1;
          flit_d       = {lbl, {(2*SW){1'b0}}, bus.pl_data};
          rem_d        = rem_q - LW'(1);
          state_d      = last_beat ? S_IDLE : S_STREAM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      src_q        <= '0;
      rem_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      src_q        <= src_d;
      rem_q        <= rem_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.pl_ready   = pl_rdy;
  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_out   = flit_q;
  assign busy           = (state_q != S_IDLE) || flit_valid_q;
  assign err_len        = err_q;
  assign pkt_count      = cnt_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: table of packet requests driven through a
// request/payload driver, expected flits queued at payload handshake and
// compared by a monitor when each flit handshakes, plus hand-written
// sequences for back-pressure, back-to-back packets and mid-packet reset.
module tb_noc_packetizer;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int PW = 64;
  localparam int LW = 5;
  localparam int FW = 2 + 2 * (XW + YW) + PW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        err_len;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  noc_packetizer_if #(.XW(XW), .YW(YW), .PW(PW), .LW(LW)) bus ();

  noc_packetizer #(
    .MESH_SIZE_X(5), .MESH_SIZE_Y(5), .PAYLOAD_DATA_WIDTH(64), .MAX_PKT_BEATS(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .err_len(err_len), .pkt_count(pkt_count)
  );

  typedef struct {
    logic [2:0]  x;
    logic [2:0]  y;
    logic [5:0]  src;
    logic [4:0]  len;
    logic [63:0] base;
    bit          rnd;
  } vec_t;

  vec_t          vt[7];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            exp_cnt = 0;
  logic [FW-1:0] exp_q[$];
  int            hs_cyc[$];

  logic rnd_mode  = 1'b0;
  logic rnd_bit   = 1'b1;
  logic rdy_force = 1'b1;
  assign bus.flit_ready = rnd_mode ? rnd_bit : rdy_force;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic logic [FW-1:0] mk_flit(input logic [2:0] x, input logic [2:0] y,
                                            input logic [5:0] s, input int len, input int i,
                                            input logic [63:0] d);
    logic [1:0] lab;
    if (len == 1)          lab = 2'd3;
    else if (i == 0)       lab = 2'd0;
    else if (i == len - 1) lab = 2'd2;
    else                   lab = 2'd1;
    if (i == 0) return {lab, x, y, s, d};
    return {lab, 12'd0, d};
  endfunction

  always begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: pop and compare each flit on handshake; check hold under stall
  logic          prev_stall = 1'b0;
  logic [FW-1:0] prev_flit  = '0;
  always begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 128'(bus.flit_valid), 128'd1);
        chk("stall_hold", 128'(bus.flit_out), 128'(prev_flit));
      end
      if (bus.flit_valid && bus.flit_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL flit_unexpected: got 0x%0h, expected no flit", bus.flit_out);
        end else begin
          chk("flit", 128'(bus.flit_out), 128'(exp_q.pop_front()));
        end
      end
      prev_stall = bus.flit_valid && !bus.flit_ready;
      prev_flit  = bus.flit_out;
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic issue_req(input logic [2:0] x, input logic [2:0] y, input logic [5:0] s,
                           input logic [4:0] len, output bit ok);
    bus.req_valid  = 1'b1;
    bus.req_x_dest = x;
    bus.req_y_dest = y;
    bus.req_src    = s;
    bus.req_len    = len;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!ok) fail("req_handshake");
  endtask

  task automatic send_beat(input logic [2:0] x, input logic [2:0] y, input logic [5:0] s,
                           input int len, input int i, input logic [63:0] d, output bit ok);
    bus.pl_valid = 1'b1;
    bus.pl_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.pl_ready) begin
        exp_q.push_back(mk_flit(x, y, s, len, i, d));
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.pl_valid = 1'b0;
    if (!ok) fail("pl_handshake");
  endtask

  task automatic send_pkt(input logic [2:0] x, input logic [2:0] y, input logic [5:0] s,
                          input logic [4:0] len, input logic [63:0] base);
    bit ok;
    bit bad;
    bad = (len == 5'd0) || (len > 5'd16);
    issue_req(x, y, s, len, ok);
    if (!ok) return;
    if (bad) begin
      @(negedge clk);
      chk("err_pulse", 128'(err_len), 128'd1);
      chk("err_noflit", 128'(bus.flit_valid), 128'd0);
      @(negedge clk);
      chk("err_clear", 128'(err_len), 128'd0);
      @(posedge clk);
      #1;
    end else begin
      chk("err_quiet", 128'(err_len), 128'd0);
      for (int i = 0; i < int'(len); i++) begin
        send_beat(x, y, s, int'(len), i, base + 64'(i), ok);
        if (!ok) break;
      end
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.flit_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seq_ok;
    vt[0] = '{3'd2, 3'd4, 6'b001000, 5'd1,  64'hDEAD_BEEF_0000_0001, 1'b0};
    vt[1] = '{3'd1, 3'd1, 6'o21,     5'd4,  64'd1,                   1'b0};
    vt[2] = '{3'd4, 3'd0, 6'o43,     5'd0,  64'd0,                   1'b0};
    vt[3] = '{3'd0, 3'd3, 6'o02,     5'd17, 64'd0,                   1'b0};
    vt[4] = '{3'd3, 3'd2, 6'o34,     5'd16, 64'hA5A5_0000_0000_0000, 1'b1};
    vt[5] = '{3'd0, 3'd0, 6'o00,     5'd2,  64'hFFFF_FFFF_FFFF_FFF0, 1'b1};
    vt[6] = '{3'd4, 3'd4, 6'o44,     5'd3,  64'h1234,                1'b0};

    bus.req_valid  = 1'b0;
    bus.req_x_dest = '0;
    bus.req_y_dest = '0;
    bus.req_src    = '0;
    bus.req_len    = '0;
    bus.pl_valid   = 1'b0;
    bus.pl_data    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flit_valid", 128'(bus.flit_valid), 128'd0);
    chk("rst_pl_ready",   128'(bus.pl_ready),   128'd0);
    chk("rst_err_len",    128'(err_len),        128'd0);
    chk("rst_busy",       128'(busy),           128'd0);
    chk("rst_pkt_count",  128'(pkt_count),      128'd0);
    chk("rst_flit_out",   128'(bus.flit_out),   128'd0);
    chk("rst_req_ready",  128'(bus.req_ready),  128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 128'(bus.req_ready), 128'd1);
    @(posedge clk);
    #1;

    // Table-driven packets
    for (int v = 0; v < 7; v++) begin
      hs_cyc.delete();
      rnd_mode = vt[v].rnd;
      send_pkt(vt[v].x, vt[v].y, vt[v].src, vt[v].len, vt[v].base);
      rnd_mode = 1'b0;
      wait_drain();
      if (vt[v].len != 5'd0 && vt[v].len <= 5'd16) exp_cnt++;
      chk("pkt_count", 128'(pkt_count), 128'(exp_cnt));
      if (!vt[v].rnd && vt[v].len > 5'd1 && vt[v].len <= 5'd16) begin
        chk("flit_total", 128'(hs_cyc.size()), 128'(vt[v].len));
        seq_ok = (hs_cyc.size() == int'(vt[v].len));
        for (int k = 0; k + 1 < hs_cyc.size(); k++)
          if (hs_cyc[k+1] - hs_cyc[k] != 1) seq_ok = 1'b0;
        chk("back_to_back_flits", 128'(seq_ok), 128'd1);
      end
    end

    // Back-pressure: router stalls 3 cycles after the HEAD flit
    hs_cyc.delete();
    rdy_force = 1'b0;
    fork
      send_pkt(3'd1, 3'd2, 6'o12, 5'd3, 64'd100);
      begin
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (bus.flit_valid) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) begin
          fail("stall_head");
        end else begin
          for (int k = 0; k < 3; k++) begin
            chk("stall_pl_ready", 128'(bus.pl_ready), 128'd0);
            chk("stall_label", 128'(bus.flit_out[FW-1 -: 2]), 128'd0);
            @(posedge clk);
          end
          #1;
        end
        rdy_force = 1'b1;
      end
    join
    wait_drain();
    exp_cnt++;
    chk("stall_pkt_count", 128'(pkt_count), 128'(exp_cnt));
    chk("stall_flit_total", 128'(hs_cyc.size()), 128'd3);

    // Back-to-back requests: len=2 then len=1
    hs_cyc.delete();
    send_pkt(3'd2, 3'd1, 6'o05, 5'd2, 64'h200);
    send_pkt(3'd3, 3'd3, 6'o05, 5'd1, 64'h300);
    wait_drain();
    exp_cnt += 2;
    chk("b2b_pkt_count", 128'(pkt_count), 128'(exp_cnt));
    chk("b2b_flit_total", 128'(hs_cyc.size()), 128'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap_head_tail", 128'(hs_cyc[1] - hs_cyc[0]), 128'd1);
      chk("b2b_gap_tail_ht",   128'(hs_cyc[2] - hs_cyc[1]), 128'd2);
    end

    // Reset after the BODY flit of a len=5 packet
    issue_req(3'd1, 3'd3, 6'o31, 5'd5, ok);
    if (ok) begin
      send_beat(3'd1, 3'd3, 6'o31, 5, 0, 64'h500, ok);
      send_beat(3'd1, 3'd3, 6'o31, 5, 1, 64'h501, ok);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_flit_valid", 128'(bus.flit_valid), 128'd0);
    chk("mid_rst_busy",       128'(busy),           128'd0);
    chk("mid_rst_req_ready",  128'(bus.req_ready),  128'd1);
    chk("mid_rst_pkt_count",  128'(pkt_count),      128'd0);
    @(posedge clk);
    #1;
    hs_cyc.delete();
    send_pkt(3'd0, 3'd1, 6'o11, 5'd1, 64'hCAFE);
    wait_drain();
    exp_cnt++;
    chk("post_rst_pkt_count", 128'(pkt_count), 128'(exp_cnt));
    chk("post_rst_flit_total", 128'(hs_cyc.size()), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
